// File: rtl/serial_uart.sv
// rtl/serial_uart.sv - full-duplex 8N1 UART with byte-wide ready/valid interfaces
module serial_uart #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       serial_in,
    output logic       serial_out
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] SYM_LAST  = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(SAMPLE_TIME);

    typedef enum logic {TX_IDLE, TX_SENDING} tx_state_t;
    typedef enum logic {RX_IDLE, RX_RECEIVING} rx_state_t;

    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [3:0]    tx_bit, tx_bit_n;
    logic [8:0]    tx_shift, tx_shift_n;
    logic          serial_out_n, data_in_ready_n;

    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [3:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic [7:0]    data_out_n;
    logic          data_out_valid_n;
    logic          rx_sync1, rx_sync2;

    // Start bit goes out on acceptance; tx_shift holds the 8 data bits plus stop bit.
    always_comb begin
        tx_state_n      = tx_state;
        tx_cnt_n        = tx_cnt;
        tx_bit_n        = tx_bit;
        tx_shift_n      = tx_shift;
        serial_out_n    = serial_out;
        data_in_ready_n = data_in_ready;
        case (tx_state)
            TX_IDLE: begin
                serial_out_n = 1'b1;
                if (data_in_valid && data_in_ready) begin
                    tx_state_n      = TX_SENDING;
                    tx_shift_n      = {1'b1, data_in};
                    serial_out_n    = 1'b0;
                    tx_cnt_n        = '0;
                    tx_bit_n        = '0;
                    data_in_ready_n = 1'b0;
                end else begin
                    data_in_ready_n = 1'b1;
                end
            end
            TX_SENDING: begin
                if (tx_cnt == SYM_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 4'd9) begin
                        tx_state_n      = TX_IDLE;
                        serial_out_n    = 1'b1;
                        data_in_ready_n = 1'b1;
                    end else begin
                        serial_out_n = tx_shift[0];
                        tx_shift_n   = {1'b0, tx_shift[8:1]};
                        tx_bit_n     = tx_bit + 4'd1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // rx_bit: 0 = start, 1..8 = data, 9 = stop; sampled mid-bit.
    always_comb begin
        rx_state_n       = rx_state;
        rx_cnt_n         = rx_cnt;
        rx_bit_n         = rx_bit;
        rx_shift_n       = rx_shift;
        data_out_n       = data_out;
        data_out_valid_n = data_out_valid;
        if (data_out_valid && data_out_ready)
            data_out_valid_n = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                if (!rx_sync2)
                    rx_state_n = RX_RECEIVING;
            end
            RX_RECEIVING: begin
                rx_cnt_n = (rx_cnt == SYM_LAST) ? '0 : rx_cnt + 1'b1;
                if (rx_cnt == SAMPLE_AT) begin
                    rx_bit_n = rx_bit + 4'd1;
                    if (rx_bit == 4'd0) begin
                        if (rx_sync2)
                            rx_state_n = RX_IDLE;
                    end else if (rx_bit == 4'd9) begin
                        rx_state_n = RX_IDLE;
                        if (rx_sync2) begin
                            data_out_n       = rx_shift;
                            data_out_valid_n = 1'b1;
                        end
                    end else begin
                        rx_shift_n = {rx_sync2, rx_shift[7:1]};
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state       <= TX_IDLE;
            tx_cnt         <= '0;
            tx_bit         <= '0;
            tx_shift       <= '0;
            serial_out     <= 1'b1;
            data_in_ready  <= 1'b0;
            rx_state       <= RX_IDLE;
            rx_cnt         <= '0;
            rx_bit         <= '0;
            rx_shift       <= '0;
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            rx_sync1       <= 1'b1;
            rx_sync2       <= 1'b1;
        end else begin
            tx_state       <= tx_state_n;
            tx_cnt         <= tx_cnt_n;
            tx_bit         <= tx_bit_n;
            tx_shift       <= tx_shift_n;
            serial_out     <= serial_out_n;
            data_in_ready  <= data_in_ready_n;
            rx_state       <= rx_state_n;
            rx_cnt         <= rx_cnt_n;
            rx_bit         <= rx_bit_n;
            rx_shift       <= rx_shift_n;
            data_out       <= data_out_n;
            data_out_valid <= data_out_valid_n;
            rx_sync1       <= serial_in;
            rx_sync2       <= rx_sync1;
        end
    end
endmodule

// File: tb/tb_serial_uart.sv
// tb/tb_serial_uart.sv - directed bench for serial_uart with an RX scoreboard
module tb_serial_uart;
    localparam int CF  = 1_000_000;
    localparam int BR  = 9_600;
    localparam int SYM = 104;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b0;
    logic       serial_in;
    logic       serial_out;
    logic       bench_line = 1'b1;
    logic       loop_en = 1'b0;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb_q[$];

    assign serial_in = loop_en ? serial_out : bench_line;
    always #5 clk = ~clk;

    serial_uart #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .serial_in(serial_in),
        .serial_out(serial_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!data_in_ready && n < 20 * SYM) begin
            cycles(1);
            n++;
        end
        check("tx_ready_timeout", {31'b0, data_in_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, output int n);
        wait_ready(n);
        data_in       = b;
        data_in_valid = 1'b1;
        cycles(1);
        data_in_valid = 1'b0;
        data_in       = ~b;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int stop_len);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            bench_line = f[i];
            cycles(SYM);
        end
        bench_line = f[9];
        cycles(stop_len);
        bench_line = 1'b1;
    endtask

    task automatic pulse_ready();
        data_out_ready = 1'b1;
        cycles(1);
        data_out_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 30 * SYM) begin
            cycles(1);
            n++;
        end
        check(tag, sb_q.size(), 0);
    endtask

    // Scoreboard: every consumed byte must match the oldest expected byte.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset && data_out_valid && data_out_ready) begin
            if (sb_q.size() != 0) e = {24'h0, sb_q.pop_front()};
            else                  e = 32'h100;
            check("rx_byte", {24'h0, data_out}, e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         diffs;
        int         rdy_hi;
        int         n;
        logic [9:0] f;
        logic [7:0] bytes [3];

        reset = 1'b0;
        cycles(30);
        check("rst_serial_out", {31'b0, serial_out}, 32'd1);
        check("rst_in_ready", {31'b0, data_in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, data_out_valid}, 32'd0);
        check("rst_data_out", {24'b0, data_out}, 32'h00);
        reset = 1'b1;
        cycles(1);
        check("ready_after_release", {31'b0, data_in_ready}, 32'd1);

        // TX 0x23, one-cycle valid pulse; data_in scrambled after acceptance
        data_in = 8'h23;
        data_in_valid = 1'b1;
        cycles(1);
        data_in_valid = 1'b0;
        data_in = 8'hDC;
        f = 10'b1_0010_0011_0;
        rdy_hi = 0;
        for (int k = 0; k < 10; k++) begin
            diffs = 0;
            for (int j = 0; j < SYM; j++) begin
                @(negedge clk);
                if (serial_out !== f[k]) diffs++;
                if (data_in_ready !== 1'b0) rdy_hi++;
            end
            check($sformatf("tx_bit%0d", k), diffs, 0);
        end
        check("tx_ready_low", rdy_hi, 0);
        @(negedge clk);
        check("tx_ready_back", {31'b0, data_in_ready}, 32'd1);
        check("tx_line_idle", {31'b0, serial_out}, 32'd1);
        cycles(1);

        // RX 0x23 held until consumed
        sb_q.push_back(8'h23);
        drive_frame(8'h23, 1'b1, SYM);
        check("rx_valid", {31'b0, data_out_valid}, 32'd1);
        check("rx_data", {24'b0, data_out}, 32'h23);
        diffs = 0;
        repeat (3 * SYM) begin
            @(negedge clk);
            if (data_out_valid !== 1'b1 || data_out !== 8'h23) diffs++;
        end
        cycles(1);
        check("rx_hold", diffs, 0);
        pulse_ready();
        check("rx_cleared", {31'b0, data_out_valid}, 32'd0);

        // Loopback, back-to-back frames
        loop_en = 1'b1;
        data_out_ready = 1'b1;
        bytes = '{8'h00, 8'hFF, 8'hA5};
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(bytes[i]);
            send_byte(bytes[i], n);
            if (i > 0) check($sformatf("b2b_wait%0d", i), n, 10 * SYM);
        end
        drain("loop_drain");
        wait_ready(n);
        loop_en = 1'b0;

        // Start-bit glitch shorter than half a bit
        bench_line = 1'b0;
        cycles(30);
        bench_line = 1'b1;
        cycles(3 * SYM);
        check("glitch_no_valid", {31'b0, data_out_valid}, 32'd0);
        check("glitch_data_kept", {24'b0, data_out}, 32'hA5);

        // Framing error: stop bit low past its sample point
        drive_frame(8'h5A, 1'b0, 70);
        cycles(3 * SYM);
        check("frame_no_valid", {31'b0, data_out_valid}, 32'd0);
        check("frame_data_kept", {24'b0, data_out}, 32'hA5);

        // Overrun: second byte replaces the first
        data_out_ready = 1'b0;
        drive_frame(8'h11, 1'b1, SYM);
        sb_q.push_back(8'h3C);
        drive_frame(8'h3C, 1'b1, SYM);
        check("ovr_valid", {31'b0, data_out_valid}, 32'd1);
        check("ovr_data", {24'b0, data_out}, 32'h3C);
        pulse_ready();
        check("ovr_cleared", {31'b0, data_out_valid}, 32'd0);

        // Reset during TX frame bit 4 (line low there for 0x96)
        send_byte(8'h96, n);
        cycles(4 * SYM + SYM / 2);
        check("txrst_line_before", {31'b0, serial_out}, 32'd0);
        reset = 1'b0;
        cycles(1);
        check("txrst_line", {31'b0, serial_out}, 32'd1);
        check("txrst_ready", {31'b0, data_in_ready}, 32'd0);
        check("txrst_data_out", {24'b0, data_out}, 32'h00);
        cycles(5);
        reset = 1'b1;
        cycles(2);

        // Reset during RX frame bit 4
        data_out_ready = 1'b1;
        f = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bench_line = f[i];
            cycles(SYM);
        end
        bench_line = f[4];
        cycles(SYM / 2);
        reset = 1'b0;
        cycles(1);
        bench_line = 1'b1;
        cycles(5);
        reset = 1'b1;
        cycles(12 * SYM);
        check("rxrst_no_valid", {31'b0, data_out_valid}, 32'd0);

        // Clean frame after both resets
        loop_en = 1'b1;
        sb_q.push_back(8'hC3);
        send_byte(8'hC3, n);
        drain("post_reset_drain");
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_uart.md
Name: serial_uart

Overview:
- Full-duplex 8N1 UART: one transmitter and one receiver sharing a clock, each with a byte-wide ready/valid interface.
- Used both as the CPU's on-chip UART and as the off-chip bench UART that drives and monitors the FPGA serial pins.
- Serial line idles high; frames are LSB-first.

Parameters:
CLOCK_FREQ, 125_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, serial bit rate in bits/s

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted)
data_in  input  8  byte to transmit
data_in_valid  input  1  data_in holds a byte to send
data_in_ready  output  1  transmitter idle; can accept a byte
data_out  output  8  last received byte
data_out_valid  output  1  data_out holds an unconsumed byte
data_out_ready  input  1  consumer takes data_out this cycle
serial_in  input  1  serial receive line (asynchronous)
serial_out  output  1  serial transmit line

Behaviour:
- Bit period: SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE, integer-truncated. The default is 1085 cycles. SAMPLE_TIME = SYMBOL_EDGE_TIME/2 (542). Counter widths are derived with $clog2.
- Frame: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1). No parity. 10 bit periods per frame.
- Reset (reset==0 at a clock edge): serial_out=1, data_in_ready=0, data_out_valid=0, data_out=8'h00, and both state machines go to IDLE.
- All outputs are registered. data_in_ready rises on the first edge after reset is released.

Transmitter:
- States: IDLE, SENDING.
- IDLE: serial_out=1, data_in_ready=1.
- Handshake: when data_in_valid && data_in_ready at an edge, latch {1'b1, data_in, 1'b0} into a shift register and move to SENDING. data_in_ready=0 from the next cycle.
- serial_out drives the start bit starting the cycle after acceptance.
- Each bit is held exactly SYMBOL_EDGE_TIME cycles.
- After the stop bit's full period, return to IDLE; data_in_ready=1 that same cycle.
- data_in and data_in_valid are ignored while SENDING. data_in need not stay stable after acceptance.
- Back-to-back: a byte presented while in IDLE is accepted immediately, so frames can be sent with no extra idle gap.

Receiver:
- serial_in passes through a 2-flop synchronizer before any use.
- States: IDLE, RECEIVING.
- IDLE: a synchronized 0 starts a frame. The sample counter restarts.
- Samples are taken at SAMPLE_TIME into each bit period: start bit, then 8 data bits shifted in LSB-first, then the stop bit.
- If the start-bit sample is 1, treat it as a glitch and return to IDLE.
- If the stop-bit sample is 0, treat it as a framing error: discard the byte and leave data_out/data_out_valid unchanged.
- On a valid stop bit, load data_out and set data_out_valid=1 at the stop-bit mid-sample. The receiver returns to IDLE right away, so it can detect the next start bit.
- data_out_valid stays high and data_out stays stable until data_out_valid && data_out_ready at an edge. data_out_valid clears the next cycle.
- Overrun: if a new byte completes while data_out_valid=1, data_out is overwritten with the new byte and data_out_valid stays 1.
- Simultaneous completion and consume in the same cycle: the new byte wins, and data_out_valid stays 1.
- Transmitter and receiver are fully independent; loopback (serial_out→serial_in) must work.
- Reset mid-frame aborts both directions. serial_out goes to 1 immediately, and a partial RX byte is never delivered.

Test Plan:
- Reset: hold reset=0 for 30 cycles -> serial_out=1, data_in_ready=0, data_out_valid=0, data_out=0. Release -> data_in_ready=1 within 1 cycle.
- TX 0x23 at default params: pulse data_in_valid for 1 cycle -> serial_out sequence 0,1,1,0,0,0,1,0,0,1, each bit held 1085 cycles. data_in_ready=0 for 10850 cycles, then 1.
- RX 0x23: bench drives the frame at 1085 cycles/bit with data_out_ready=0 -> data_out_valid=1 with data_out=0x23 about 4 cycles after the stop-bit midpoint, held until data_out_ready=1 for 1 cycle, then cleared.
- Loopback, back-to-back: send 0x00, 0xFF, 0xA5 as fast as data_in_ready allows with data_out_ready=1 -> the same three bytes are received in order, and no idle gap appears between TX frames.
- Errors: a 200-cycle low glitch on serial_in -> no byte. A frame with stop bit=0 -> no data_out_valid. Overrun: two frames with data_out_ready=0 -> data_out = second byte.
- Mid-frame reset: assert reset during TX bit 4 and during RX bit 4 -> serial_out=1 at once, no data_out_valid, and the next clean frame transfers correctly.
